// File: rtl/v3_packet_loopback_ctrl.sv
// ---------------------------------------------------------------------------
// v3_packet_loopback_ctrl
//
// Packet loopback controller for an FT60x (FT600/FT601) style interface.
// Words received on the rx side are stored together with their byte enables
// in a packet buffer. A packet is returned on the tx side in arrival order
// once it is full, or earlier if the rx side stays idle for TIMEOUT_CYC
// cycles (partial flush).
//
// Optional feature macro: LOOPBACK_CHECKSUM_EN
//   When defined, every returned packet is followed by one extra tx word that
//   holds the sum of the returned data words (mod 2^DATA_WIDTH), with all byte
//   enables set. When undefined, the checksum state and adder are not built.
// ---------------------------------------------------------------------------
module v3_packet_loopback_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int PKT_WORDS   = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic [DATA_WIDTH/8-1:0] rx_be,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic [DATA_WIDTH/8-1:0] tx_be,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [15:0]             pkt_count,
    output logic                    overflow_err,
    output logic                    busy
);

    // Byte-enable width, buffer address width, word-count width (must hold
    // PKT_WORDS itself), idle-counter width and stored entry width.
    localparam int BEW = DATA_WIDTH / 8;
    localparam int AW  = $clog2(PKT_WORDS);
    localparam int CW  = AW + 1;
    localparam int IW  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int EW  = BEW + DATA_WIDTH;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
`ifdef LOOPBACK_CHECKSUM_EN
    localparam logic [1:0] ST_CKSUM = 2'd3;
`endif

    // Registered state
    logic [1:0]            r_state;
    logic [CW-1:0]         r_wr_cnt;
    logic [AW-1:0]         r_rd_idx;
    logic [CW-1:0]         r_len;
    logic [IW-1:0]         r_idle_cnt;
    logic [15:0]           r_pkt_count;
    logic                  r_overflow;
    logic                  r_rx_en;
`ifdef LOOPBACK_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
`endif

    // Packet buffer: {be, data} per entry; not reset, contents are only
    // meaningful for words written in the current packet.
    logic [EW-1:0]         r_buf [PKT_WORDS];

    // Combinational helpers
    logic                  w_rx_ready;
    logic                  w_accept;
    logic                  w_tx_valid;
    logic                  w_tx_xfer;
    logic [EW-1:0]         w_rd_word;
    logic                  w_last;
    logic [CW-1:0]         w_wr_cnt_inc;
    logic [IW-1:0]         w_idle_inc;
    logic [AW-1:0]         w_wr_idx;

    // Next-state values
    logic [1:0]            w_state_nxt;
    logic [CW-1:0]         w_wr_cnt_nxt;
    logic [AW-1:0]         w_rd_idx_nxt;
    logic [CW-1:0]         w_len_nxt;
    logic [IW-1:0]         w_idle_nxt;
    logic [15:0]           w_pkt_nxt;
`ifdef LOOPBACK_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] w_sum_nxt;
`endif

    // rx is only accepted once reset has been released for one edge and the
    // controller is collecting a packet.
    assign w_rx_ready   = r_rx_en & ((r_state == ST_IDLE) | (r_state == ST_RECV));
    assign w_accept     = rx_valid & w_rx_ready;
`ifdef LOOPBACK_CHECKSUM_EN
    assign w_tx_valid   = (r_state == ST_SEND) | (r_state == ST_CKSUM);
`else
    assign w_tx_valid   = (r_state == ST_SEND);
`endif
    assign w_tx_xfer    = w_tx_valid & tx_ready;
    assign w_rd_word    = r_buf[r_rd_idx];
    assign w_last       = ({1'b0, r_rd_idx} == (r_len - CW'(1)));
    assign w_wr_cnt_inc = r_wr_cnt + CW'(1);
    assign w_idle_inc   = r_idle_cnt + IW'(1);
    assign w_wr_idx     = r_wr_cnt[AW-1:0];

    // Next-state and counter update logic of the loopback controller
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_idx_nxt = r_rd_idx;
        w_len_nxt    = r_len;
        w_idle_nxt   = r_idle_cnt;
        w_pkt_nxt    = r_pkt_count;
`ifdef LOOPBACK_CHECKSUM_EN
        w_sum_nxt    = r_sum;
`endif
        case (r_state)
            ST_IDLE, ST_RECV: begin
                if (w_accept) begin
                    // An accept always wins over a coincident timeout.
                    w_wr_cnt_nxt = w_wr_cnt_inc;
                    w_idle_nxt   = '0;
                    if (w_wr_cnt_inc == CW'(PKT_WORDS)) begin
                        w_state_nxt  = ST_SEND;
                        w_len_nxt    = CW'(PKT_WORDS);
                        w_rd_idx_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_RECV;
                    end
                end else if (r_state == ST_RECV) begin
                    if ((TIMEOUT_CYC > 0) && (w_idle_inc == IW'(TIMEOUT_CYC))) begin
                        // Partial flush of what has been collected so far.
                        w_state_nxt  = ST_SEND;
                        w_len_nxt    = r_wr_cnt;
                        w_rd_idx_nxt = '0;
                        w_idle_nxt   = '0;
                    end else begin
                        w_idle_nxt   = w_idle_inc;
                    end
                end else begin
                    w_idle_nxt = '0;
                end
            end
            ST_SEND: begin
                if (w_tx_xfer) begin
`ifdef LOOPBACK_CHECKSUM_EN
                    w_sum_nxt = r_sum + w_rd_word[DATA_WIDTH-1:0];
`endif
                    if (w_last) begin
                        w_wr_cnt_nxt = '0;
                        w_rd_idx_nxt = '0;
                        w_idle_nxt   = '0;
`ifdef LOOPBACK_CHECKSUM_EN
                        w_state_nxt  = ST_CKSUM;
`else
                        w_state_nxt  = ST_IDLE;
                        w_pkt_nxt    = r_pkt_count + 16'd1;
`endif
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + AW'(1);
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
`ifdef LOOPBACK_CHECKSUM_EN
            ST_CKSUM: begin
                if (w_tx_xfer) begin
                    // Packet is complete only once its checksum word is out.
                    w_state_nxt = ST_IDLE;
                    w_pkt_nxt   = r_pkt_count + 16'd1;
                    w_sum_nxt   = '0;
                end else begin
                    w_state_nxt = ST_CKSUM;
                end
            end
`endif
            default: begin
                w_state_nxt  = ST_IDLE;
                w_wr_cnt_nxt = '0;
                w_rd_idx_nxt = '0;
                w_idle_nxt   = '0;
            end
        endcase
    end

    // Controller state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_cnt    <= '0;
            r_rd_idx    <= '0;
            r_len       <= '0;
            r_idle_cnt  <= '0;
            r_pkt_count <= 16'd0;
            r_overflow  <= 1'b0;
            r_rx_en     <= 1'b0;
`ifdef LOOPBACK_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_len       <= w_len_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_pkt_count <= w_pkt_nxt;
            // Sticky: an rx word offered while not ready is dropped and flagged.
            r_overflow  <= r_overflow | (rx_valid & ~w_rx_ready);
            r_rx_en     <= 1'b1;
`ifdef LOOPBACK_CHECKSUM_EN
            r_sum       <= w_sum_nxt;
`endif
        end
    end

    // Packet buffer write on every rx accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[w_wr_idx] <= {rx_be, rx_data};
        end
    end

    // tx word selection: buffered word in SEND, checksum in CKSUM, zero otherwise
    always_comb begin
        tx_data = '0;
        tx_be   = '0;
        case (r_state)
            ST_SEND: begin
                tx_data = w_rd_word[DATA_WIDTH-1:0];
                tx_be   = w_rd_word[EW-1:DATA_WIDTH];
            end
`ifdef LOOPBACK_CHECKSUM_EN
            ST_CKSUM: begin
                tx_data = r_sum;
                tx_be   = '1;
            end
`endif
            default: begin
                tx_data = '0;
                tx_be   = '0;
            end
        endcase
    end

    assign rx_ready     = w_rx_ready;
    assign tx_valid     = w_tx_valid;
    assign pkt_count    = r_pkt_count;
    assign overflow_err = r_overflow;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_v3_packet_loopback_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for v3_packet_loopback_ctrl (DATA_WIDTH=16, PKT_WORDS=8,
// TIMEOUT_CYC=16). Expected tx traffic comes from a packet-level queue model:
// words accumulate in the current packet, which is released in order once it
// holds PKT_WORDS words or the timeout expires (plus a sum word when
// LOOPBACK_CHECKSUM_EN is defined).
// ---------------------------------------------------------------------------
module tb_v3_packet_loopback_ctrl;

    localparam int DW  = 16;
    localparam int BEW = 2;
    localparam int PW  = 8;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  rx_data;
    logic [BEW-1:0] rx_be;
    logic           rx_valid;
    logic           rx_ready;
    logic [DW-1:0]  tx_data;
    logic [BEW-1:0] tx_be;
    logic           tx_valid;
    logic           tx_ready;
    logic [15:0]    pkt_count;
    logic           overflow_err;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW+BEW-1:0] cur_q[$];
    logic [DW+BEW-1:0] exp_q[$];
    int                exp_pkt = 0;

    v3_packet_loopback_ctrl #(
        .DATA_WIDTH  (DW),
        .PKT_WORDS   (PW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_be        (rx_be),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_be        (tx_be),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .pkt_count    (pkt_count),
        .overflow_err (overflow_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release the current packet into the expected tx stream.
    task automatic close_pkt();
        logic [DW-1:0] sum;
        sum = '0;
        foreach (cur_q[i]) begin
            exp_q.push_back(cur_q[i]);
            sum = sum + cur_q[i][DW-1:0];
        end
`ifdef LOOPBACK_CHECKSUM_EN
        exp_q.push_back({2'b11, sum});
`endif
        cur_q.delete();
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic [BEW-1:0] be);
        rx_data  = d;
        rx_be    = be;
        rx_valid = 1'b1;
        chk("rx_ready_recv", {31'd0, rx_ready}, 32'd1);
        step();
        rx_valid = 1'b0;
        cur_q.push_back({be, d});
        if (cur_q.size() == PW) begin
            close_pkt();
            chk("tx_valid_latency", {31'd0, tx_valid}, 32'd1);
        end else begin
            chk("tx_valid_low_recv", {31'd0, tx_valid}, 32'd0);
            chk("busy_recv", {31'd0, busy}, 32'd1);
        end
    endtask

    // Drain the expected stream; mode 0 always ready, 1 ready pattern 1-0-0-1, 2 random.
    task automatic recv_all(input int mode);
        int   budget;
        int   ph;
        logic r;
        budget = 500;
        ph     = 0;
        while (exp_q.size() > 0 && budget > 0) begin
            chk("tx_valid_send", {31'd0, tx_valid}, 32'd1);
            chk("tx_word", {14'd0, tx_be, tx_data}, {14'd0, exp_q[0]});
            case (mode)
                0:       r = 1'b1;
                1:       r = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ph++;
            tx_ready = r;
            step();
            budget--;
            if (r) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_pkt++;
            end
        end
        tx_ready = 1'b0;
        chk("drain_budget", exp_q.size(), 32'd0);
        chk("tx_valid_done", {31'd0, tx_valid}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("pkt_count", {16'd0, pkt_count}, 32'(exp_pkt & 16'hFFFF));
    endtask

    task automatic wait_timeout();
        int lat;
        lat = 0;
        while (tx_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        chk("timeout_latency", lat, TO);
        close_pkt();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pkt_count"}, {16'd0, pkt_count}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow_err}, 32'd0);
        chk({tag, "_tx_data"}, {16'd0, tx_data}, 32'd0);
        chk({tag, "_tx_be"}, {30'd0, tx_be}, 32'd0);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_be    = '0;
        tx_ready = 1'b0;

        // Reset state
        #2;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rx_ready_before_edge", {31'd0, rx_ready}, 32'd0);
        step();
        chk("rx_ready_after_edge", {31'd0, rx_ready}, 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Full packet 1..8, tx always ready
        for (int i = 1; i <= PW; i++) send_word(DW'(i), 2'b11);
        recv_all(0);

        // Three words then idle: partial flush by timeout
        for (int i = 0; i < 3; i++) send_word(DW'($urandom()), 2'($urandom_range(0, 3)));
        wait_timeout();
        recv_all(0);

        // Backpressure pattern 1-0-0-1
        for (int i = 0; i < PW; i++) send_word(DW'($urandom()), 2'($urandom_range(0, 3)));
        recv_all(1);

        // rx word offered while sending: flagged and discarded
        for (int i = 0; i < PW; i++) send_word(DW'($urandom()), 2'($urandom_range(0, 3)));
        rx_data  = 16'hDEAD;
        rx_be    = 2'b01;
        rx_valid = 1'b1;
        chk("rx_ready_send", {31'd0, rx_ready}, 32'd0);
        step();
        rx_valid = 1'b0;
        chk("overflow_set", {31'd0, overflow_err}, 32'd1);
        recv_all(2);
        chk("overflow_sticky", {31'd0, overflow_err}, 32'd1);

        // Random full packets with a data-wrapping word, then a random partial
        for (int p = 0; p < 4; p++) begin
            send_word(16'hFFFF, 2'b11);
            for (int i = 1; i < PW; i++) send_word(DW'($urandom()), 2'($urandom_range(0, 3)));
            recv_all(2);
        end
        n = $urandom_range(1, PW - 1);
        for (int i = 0; i < n; i++) send_word(DW'($urandom()), 2'($urandom_range(0, 3)));
        wait_timeout();
        recv_all(2);

        // Reset after 5 of 8 words: packet discarded, fresh packet works
        for (int i = 0; i < 5; i++) send_word(DW'($urandom()), 2'($urandom_range(0, 3)));
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cur_q.delete();
        exp_pkt = 0;
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < PW; i++) send_word(DW'(16'h0100 + i), 2'($urandom_range(0, 3)));
        recv_all(2);
        chk("overflow_cleared", {31'd0, overflow_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
